fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have these parameters:
- XLEN, 64, address and PC width.
- RESET_PC, 64'h0, PC loaded at reset.
- FQ_DEPTH, 4, fetch queue entries; power of two, minimum 2.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- PCSrcD  in  1  branch-taken redirect.
- JalD  in  1  jump redirect.
- PCTargetD  in  XLEN  redirect target.
- StallD  in  1  decode cannot accept.
- ValidD  out  1  InstrD, PCD and PCPlus4D are valid.
- InstrD  out  32  head instruction.
- PCD  out  XLEN  head PC.
- PCPlus4D  out  XLEN  PCD+4.
- perf_fetch_cnt  out  32  instructions delivered to decode.
- perf_flush_cnt  out  32  redirect events.

Function
REQ-003 The fetch PC pc_f SHALL drive imem_req_addr and SHALL advance by 4 (mod 2^XLEN) on each accepted request (imem_req_valid & imem_req_ready).
REQ-004 The queue SHALL use three pointers:
- tail: an entry is allocated at request acceptance, storing its PC.
- fill: each response fills the oldest unfilled entry.
- head: the oldest entry; popped by decode.
REQ-005 imem_req_valid SHALL be 1 only when allocated entries < FQ_DEPTH and no redirect is asserted this cycle.
REQ-006 ValidD SHALL be 1 exactly when the head entry is filled.
REQ-007 When ValidD=0, outputs SHALL be InstrD=32'h00000013, PCD=0 and PCPlus4D=0.
REQ-008 A pop SHALL occur on ValidD & !StallD; while StallD=1, the head outputs SHALL hold stable.
REQ-009 A redirect is PCSrcD|JalD. On a redirect cycle:
- the next pc_f SHALL be {PCTargetD[XLEN-1:2],2'b00};
- all queue entries SHALL be discarded;
- no request SHALL be issued;
- no pop SHALL occur.
REQ-010 At redirect, drop_cnt SHALL be loaded with the number of accepted-but-unfilled requests, minus 1 if imem_rsp_valid is asserted in the same cycle.
REQ-011 While drop_cnt>0, each response SHALL decrement drop_cnt and SHALL be discarded.
REQ-012 A response arriving with no unfilled entry and drop_cnt=0 is a protocol error and SHALL be ignored.
REQ-013 A simultaneous allocate, fill and pop in one cycle SHALL all take effect with no loss.
REQ-014 Latency: with a memory that returns responses one cycle after acceptance, the first ValidD SHALL occur 2 cycles after rst deasserts. Steady-state throughput SHALL be 1 instruction per cycle.
REQ-015 All pointers SHALL wrap modulo FQ_DEPTH. pc_f and PCPlus4D SHALL wrap modulo 2^XLEN.

Reset
REQ-016 While rst=0, asynchronously:
- pc_f=RESET_PC;
- head, fill and tail pointers and drop_cnt =0;
- all entries unfilled;
- ValidD=0 and imem_req_valid=0;
- perf counters =0.
REQ-017 A reset asserted mid-operation SHALL abandon all in-flight requests without draining. Memory reset is the environment's responsibility.

Configuration
REQ-018 With macro FETCH_PERF_EN defined:
- perf_fetch_cnt SHALL increment on each pop;
- perf_flush_cnt SHALL increment on each redirect cycle;
- both SHALL wrap at 2^32.
REQ-019 With FETCH_PERF_EN undefined, both perf outputs SHALL be constant 0 and SHALL contain no counter registers.

Verification
REQ-020 Reset release, RESET_PC=0, zero-wait memory, StallD=0 -> PCD sequence 0x0,0x4,0x8,... one per cycle from cycle 2; PCPlus4D=PCD+4.
REQ-021 StallD=1 for 10 cycles, FQ_DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0. InstrD/PCD stay stable. On release, order is preserved.
REQ-022 JalD=1, PCTargetD=0x100 with 2 requests in flight -> the 2 late responses are dropped, the next request address is 0x100, and no stale PC reaches ValidD.
REQ-023 PCSrcD=1, PCTargetD=0x203, with a response in the same cycle -> next imem_req_addr=0x200, and drop_cnt equals unfilled-1.
REQ-024 rst=0 for one cycle mid-stream, memory random-ready -> ValidD=0 immediately, and fetch restarts at RESET_PC.
REQ-025 With FETCH_PERF_EN, 20 pops and 3 redirects -> perf_fetch_cnt=20 and perf_flush_cnt=3. Without the macro, both read 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus the decode-side handshake.
// The master modport is the fetch unit; the slave modport is the memory/decode environment.
interface fetch_unit_if #(parameter int XLEN = 64);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            PCSrcD;
  logic            JalD;
  logic [XLEN-1:0] PCTargetD;
  logic            StallD;
  logic            ValidD;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;

  modport master (
    output imem_req_valid, imem_req_addr, ValidD, InstrD, PCD, PCPlus4D,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, PCSrcD, JalD, PCTargetD, StallD
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, ValidD, InstrD, PCD, PCPlus4D,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, PCSrcD, JalD, PCTargetD, StallD
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generator, in-order fetch queue (tail/fill/head) and stale-response dropping.
// Define FETCH_PERF_EN to build the fetch/flush performance counters; otherwise both read 0.
module fetch_unit_entry #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_alloc,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_fill,
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr
);
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= '0;
      r_instr <= 32'h0000_0013;
    end else begin
      if (i_alloc) r_pc    <= i_pc;
      if (i_fill)  r_instr <= i_instr;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
endmodule

module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        bus,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_flush_cnt
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int DW = 16;

  logic [XLEN-1:0] r_pc;
  logic [PW:0]     r_head, r_fill, r_tail;
  logic [DW-1:0]   r_drop_cnt;

  logic            w_redir, w_full, w_req_valid, w_acc, w_valid, w_pop, w_fill, w_rsp_drop;
  logic [PW:0]     w_alloc_n, w_unfill_n;
  logic [DW-1:0]   w_inflight, w_drop_ld;
  logic [XLEN-1:0] w_tgt, w_head_pc;
  logic [31:0]     w_head_instr;
  logic [FQ_DEPTH-1:0]           w_alloc_vec, w_fill_vec;
  logic [FQ_DEPTH-1:0][XLEN-1:0] w_ent_pc;
  logic [FQ_DEPTH-1:0][31:0]     w_ent_instr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_redir     = bus.PCSrcD | bus.JalD;
  assign w_alloc_n   = r_tail - r_head;
  assign w_unfill_n  = r_tail - r_fill;
  assign w_full      = (w_alloc_n == (PW+1)'(FQ_DEPTH));
  assign w_req_valid = rst & ~w_full & ~w_redir;
  assign w_acc       = w_req_valid & bus.imem_req_ready;
  assign w_valid     = (r_fill != r_head);
  assign w_pop       = w_valid & ~bus.StallD & ~w_redir;
  assign w_rsp_drop  = bus.imem_rsp_valid & ~w_redir & (r_drop_cnt != '0);
  assign w_fill      = bus.imem_rsp_valid & ~w_redir & (r_drop_cnt == '0) & (w_unfill_n != '0);
  assign w_tgt       = bus.PCTargetD & ~XLEN'(3);

  // Stale responses still owed from an earlier redirect are folded in, so back-to-back
  // redirects never let an old response fill a new entry.
  assign w_inflight  = r_drop_cnt + DW'(w_unfill_n);
  assign w_drop_ld   = w_inflight - DW'(bus.imem_rsp_valid && (w_inflight != '0));

  for (genvar g = 0; g < FQ_DEPTH; g++) begin : g_ent
    assign w_alloc_vec[g] = w_acc  & (r_tail[PW-1:0] == PW'(g));
    assign w_fill_vec[g]  = w_fill & (r_fill[PW-1:0] == PW'(g));
    fetch_unit_entry #(.XLEN(XLEN)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .i_alloc (w_alloc_vec[g]),
      .i_pc    (r_pc),
      .i_fill  (w_fill_vec[g]),
      .i_instr (bus.imem_rsp_data),
      .o_pc    (w_ent_pc[g]),
      .o_instr (w_ent_instr[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_drop_cnt <= '0;
    end else if (w_redir) begin
      r_pc       <= w_tgt;
      r_head     <= r_tail;
      r_fill     <= r_tail;
      r_drop_cnt <= w_drop_ld;
    end else begin
      if (w_acc) begin
        r_pc   <= r_pc + XLEN'(4);
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop)      r_head     <= r_head + 1'b1;
      if (w_fill)     r_fill     <= r_fill + 1'b1;
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  assign w_head_pc    = w_ent_pc[r_head[PW-1:0]];
  assign w_head_instr = w_ent_instr[r_head[PW-1:0]];

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.ValidD         = w_valid;
  assign bus.InstrD         = w_valid ? w_head_instr : 32'h0000_0013;
  assign bus.PCD            = w_valid ? w_head_pc : '0;
  assign bus.PCPlus4D       = w_valid ? (w_head_pc + XLEN'(4)) : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pop)   r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_redir) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a queue-based reference model and an in-order memory.
module tb_fetch_unit;
  localparam int          XLEN = 64;
  localparam int          D    = 4;
  localparam logic [63:0] RPC  = 64'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus();
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .FQ_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  typedef struct { logic [63:0] pc; bit filled; logic [31:0] instr; } ent_t;
  ent_t        fq[$];
  logic [63:0] mem_q[$];
  logic [63:0] m_pc;
  int          m_drop;
  logic [31:0] m_fetch, m_flush;
  int          n_assert = 0, n_fail = 0, n_acc = 0;
  bit          mem_hold, rdy_rand, rsp_rand;
  bit          s_acc, s_pop, s_rsp, s_redir;
  logic [31:0] s_data;
  logic [63:0] s_tgt, s_addr;

  function automatic logic [31:0] f_instr(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F03;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    bit ev, erv;
    logic [63:0] hpc;
    logic [31:0] hins;
    ev = 0; hpc = '0; hins = 32'h13;
    if (rst && fq.size() > 0) if (fq[0].filled) begin ev = 1; hpc = fq[0].pc; hins = fq[0].instr; end
    erv = rst && !(bus.PCSrcD || bus.JalD) && (fq.size() < D);
    chk("req_valid", bus.imem_req_valid, erv);
    if (rst) chk("req_addr", bus.imem_req_addr, m_pc);
    chk("ValidD", bus.ValidD, ev);
    chk("InstrD", bus.InstrD, hins);
    chk("PCD", bus.PCD, hpc);
    chk("PCPlus4D", bus.PCPlus4D, ev ? hpc + 64'd4 : 64'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_flush", perf_flush_cnt, m_flush);
`else
    chk("perf_fetch", perf_fetch_cnt, 0);
    chk("perf_flush", perf_flush_cnt, 0);
`endif
    s_redir = bus.PCSrcD || bus.JalD;
    s_acc   = bus.imem_req_valid && bus.imem_req_ready;
    s_pop   = ev && !bus.StallD && !s_redir;
    s_rsp   = bus.imem_rsp_valid;
    s_data  = bus.imem_rsp_data;
    s_tgt   = bus.PCTargetD;
    s_addr  = bus.imem_req_addr;
  endtask

  task automatic update();
    int unf;
    bit done;
    if (!rst) return;
    if (s_acc) begin mem_q.push_back(s_addr); n_acc++; end
    if (s_redir) begin
      unf = 0;
      foreach (fq[i]) if (!fq[i].filled) unf++;
      m_drop = m_drop + unf;
      if (s_rsp && m_drop > 0) m_drop--;
      fq.delete();
      m_pc = s_tgt & ~64'h3;
      m_flush++;
    end else begin
      if (s_pop) begin void'(fq.pop_front()); m_fetch++; end
      if (s_rsp) begin
        if (m_drop > 0) m_drop--;
        else begin
          done = 0;
          foreach (fq[i]) if (!done && !fq[i].filled) begin fq[i].filled = 1; fq[i].instr = s_data; done = 1; end
        end
      end
      if (s_acc) begin fq.push_back('{m_pc, 1'b0, 32'h0}); m_pc = m_pc + 64'd4; end
    end
  endtask

  task automatic drive_mem();
    logic [63:0] a;
    if (mem_q.size() > 0 && !mem_hold && (!rsp_rand || $urandom_range(0, 2) != 0)) begin
      a = mem_q.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = f_instr(a);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
    update();
    drive_mem();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fq.delete(); mem_q.delete();
    m_pc = RPC; m_drop = 0; m_fetch = '0; m_flush = '0; n_acc = 0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.imem_req_ready = 1'b0;
    bus.PCSrcD = 1'b0; bus.JalD = 1'b0; bus.PCTargetD = '0; bus.StallD = 1'b0;
    #1;
    chk("rst_ValidD", bus.ValidD, 0);
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_PCD", bus.PCD, 0);
    chk("rst_req_addr", bus.imem_req_addr, RPC);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_mem();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    mem_hold = 0; rdy_rand = 0; rsp_rand = 0;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_InstrD", bus.InstrD, 32'h13);
    chk("rst_PCPlus4D", bus.PCPlus4D, 0);
    chk("rst_perf_fetch", perf_fetch_cnt, 0);
    chk("rst_perf_flush", perf_flush_cnt, 0);
    chk("rst_drop_cnt", dut.r_drop_cnt, 0);

    // Zero-wait streaming: first ValidD two cycles after release, one PC per cycle.
    release_rst();
    cyc(); chk("lat_c1_ValidD", bus.ValidD, 0);
    cyc(); chk("lat_c2_ValidD", bus.ValidD, 1); chk("lat_c2_PCD", bus.PCD, 0);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("stream_PCD", bus.PCD, 64'(4 * i));
      chk("stream_PCPlus4D", bus.PCPlus4D, 64'(4 * i + 4));
    end

    // Decode stall from the start: queue fills, requests stop, head holds.
    do_reset(); bus.StallD = 1'b1; release_rst();
    repeat (10) cyc();
    chk("stall_accepts", n_acc, D);
    chk("stall_req_valid", bus.imem_req_valid, 0);
    chk("stall_PCD", bus.PCD, 0);
    chk("stall_InstrD", bus.InstrD, f_instr(64'h0));
    bus.StallD = 1'b0;
    cyc(); chk("unstall_PCD", bus.PCD, 64'h4);
    repeat (8) cyc();

    // Jump with two requests in flight: both late responses dropped.
    do_reset(); mem_hold = 1; release_rst();
    cyc(); cyc();
    bus.JalD = 1'b1; bus.PCTargetD = 64'h100;
    cyc();
    chk("jal_drop_cnt", dut.r_drop_cnt, 2);
    bus.JalD = 1'b0; mem_hold = 0;
    chk("jal_next_addr", bus.imem_req_addr, 64'h100);
    k = 0;
    while (!bus.ValidD && k < 12) begin cyc(); k++; end
    chk("jal_first_PCD", bus.PCD, 64'h100);
    repeat (6) cyc();

    // Branch to unaligned target with a response in the same cycle.
    do_reset(); mem_hold = 1; release_rst();
    cyc(); cyc(); cyc();
    bus.PCSrcD = 1'b1; bus.PCTargetD = 64'h203; mem_hold = 0; drive_mem();
    cyc();
    chk("br_drop_cnt", dut.r_drop_cnt, 2);
    chk("br_next_addr", bus.imem_req_addr, 64'h200);
    bus.PCSrcD = 1'b0;
    repeat (10) cyc();

    // Perf counters: exactly 20 pops then 3 redirects.
    do_reset(); release_rst();
    k = 0;
    while (m_fetch != 32'd20 && k < 100) begin cyc(); k++; end
    bus.StallD = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bus.PCSrcD = 1'b1; bus.PCTargetD = 64'(32'h40 * r);
      cyc();
      bus.PCSrcD = 1'b0;
      cyc();
    end
`ifdef FETCH_PERF_EN
    chk("perf20_fetch", perf_fetch_cnt, 20);
    chk("perf3_flush", perf_flush_cnt, 3);
`else
    chk("perf20_fetch", perf_fetch_cnt, 0);
    chk("perf3_flush", perf_flush_cnt, 0);
`endif
    bus.StallD = 1'b0;

    // Randomized traffic with a mid-stream reset pulse.
    do_reset(); rdy_rand = 1; rsp_rand = 1; release_rst();
    for (int i = 0; i < 1500; i++) begin
      bus.StallD = ($urandom_range(0, 3) == 0);
      bus.PCSrcD = 1'b0; bus.JalD = 1'b0;
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 1) == 0) bus.PCSrcD = 1'b1; else bus.JalD = 1'b1;
        bus.PCTargetD = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF6 : {$urandom, $urandom};
      end
      if (i == 700) begin
        #2;
        do_reset();
        chk("midrst_InstrD", bus.InstrD, 32'h13);
        release_rst();
      end else begin
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
